// File: rtl/param_stack.sv
// Parametrised operand stack with PUSH/POP/REPLACE/DUP/SWAP/DROP and sticky error flags.
// Latency: single-cycle ops; tos/nos/count update after the sampling edge, pop_valid pulses one cycle after POP.
// Backpressure: none; an op every cycle is accepted, and impossible ops raise overflow/underflow without side effects.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_PUSH    = 3'b001,
        OP_POP     = 3'b010,
        OP_REPLACE = 3'b011,
        OP_DUP     = 3'b100,
        OP_SWAP    = 3'b101,
        OP_DROP    = 3'b110,
        OP_RSVD    = 3'b111
    } op_e;

    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] pop_data_q, pop_data_d;
    logic             pop_valid_q, pop_valid_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    op_e              op_sel;
    logic [IDX_W-1:0] top_idx, nos_idx, free_idx;
    logic             has_one, has_two, is_full;
    logic             ovf_set, udf_set;
    logic [WIDTH-1:0] tos_val, nos_val;

    assign op_sel   = op_e'(op);
    // Index of the top entry, the one below it, and the first free slot;
    // only used when the corresponding guard says the slot exists.
    assign top_idx  = IDX_W'(count_q - CNT_W'(1));
    assign nos_idx  = IDX_W'(count_q - CNT_W'(2));
    assign free_idx = IDX_W'(count_q);
    assign has_one  = (count_q != '0);
    assign has_two  = (count_q > CNT_W'(1));
    assign is_full  = (count_q == DEPTH_C);
    assign tos_val  = has_one ? stack_q[top_idx] : '0;
    assign nos_val  = has_two ? stack_q[nos_idx] : '0;

    // Decode the op into next storage/count/pop state plus error strobes.
    always_comb begin
        stack_d     = stack_q;
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        ovf_set     = 1'b0;
        udf_set     = 1'b0;
        if (op_valid) begin
            case (op_sel)
                OP_PUSH: begin
                    if (is_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stack_d[free_idx] = din;
                        count_d           = count_q + CNT_W'(1);
                    end
                end
                OP_POP: begin
                    if (!has_one) begin
                        udf_set = 1'b1;
                    end else begin
                        pop_data_d  = tos_val;
                        pop_valid_d = 1'b1;
                        count_d     = count_q - CNT_W'(1);
                    end
                end
                OP_REPLACE: begin
                    if (!has_one) udf_set = 1'b1;
                    else          stack_d[top_idx] = din;
                end
                OP_DUP: begin
                    // Empty is reported before full (only matters when DEPTH is degenerate).
                    if (!has_one) begin
                        udf_set = 1'b1;
                    end else if (is_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        stack_d[free_idx] = tos_val;
                        count_d           = count_q + CNT_W'(1);
                    end
                end
                OP_SWAP: begin
                    if (!has_two) begin
                        udf_set = 1'b1;
                    end else begin
                        stack_d[top_idx] = nos_val;
                        stack_d[nos_idx] = tos_val;
                    end
                end
                OP_DROP: begin
                    if (!has_one) udf_set = 1'b1;
                    else          count_d = count_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = (ovf_q & ~clr_err) | ovf_set;
        udf_d = (udf_q & ~clr_err) | udf_set;
    end

    // Control state: cleared asynchronously so tos/nos read 0 straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // Storage array is not reset; entries above count are never observable.
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign tos       = tos_val;
    assign nos       = nos_val;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign count     = count_q;
    assign empty     = !has_one;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised hardware operand stack; successor to the processor's fixed 8-bit stack used by the PUSH/PUSH_I/PUSH_T/POP instructions.
- Generalised in data width and depth.
- Adds REPLACE, DUP, SWAP and DROP operations, sticky overflow/underflow error flags, an occupancy count, a registered pop-data handshake, and NOS (next-on-stack) visibility for future two-operand ALU ops.
- Sits between the control unit (op issue) and the datapath (RAM write-back, ALU operands).

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of stack entries; must be 2 or more.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- op_valid  input  1  op strobe; op is sampled when high.
- op  input  3  000 NOP, 001 PUSH, 010 POP, 011 REPLACE, 100 DUP, 101 SWAP, 110 DROP, 111 reserved (treated as NOP).
- din  input  WIDTH  data for PUSH and REPLACE.
- clr_err  input  1  clears the sticky error flags.
- tos  output  WIDTH  top-of-stack entry; 0 when empty.
- nos  output  WIDTH  entry below top; 0 when count < 2.
- pop_data  output  WIDTH  value removed by the last POP; holds until the next successful POP.
- pop_valid  output  1  one-cycle pulse, asserted the cycle after a successful POP.
- count  output  CNT_W  number of valid entries, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky: set when an op needed space the stack did not have.
- underflow  output  1  sticky: set when an op needed more entries than the stack held.

Behaviour:
- Reset (reset low, asynchronous):
  - count=0, pop_data=0, pop_valid=0, overflow=0, underflow=0.
  - Storage array need not be cleared; tos and nos read 0 via the count gating.
  - Reset asserted mid-operation aborts the op; the first op after release is honoured on the first rising edge.
- Single-cycle ops: the effect is visible on tos/nos/count/empty/full immediately after the rising edge that sampled op_valid.
- tos and nos are combinational reads of registered state (stack[count-1], stack[count-2]), gated to 0 when the entry does not exist.
- PUSH: if count < DEPTH, stack[count]=din and count+1; if full, no state change and overflow=1.
- POP: if count > 0, pop_data=tos, count-1, and pop_valid=1 for exactly the next cycle; if empty, no change, underflow=1, no pop_valid.
- REPLACE: if count > 0, tos=din with count unchanged; if empty, underflow=1 and no change.
- DUP: requires 1 <= count < DEPTH; pushes a copy of tos.
  - If empty: underflow=1 (takes priority over overflow).
  - If full: overflow=1.
  - In either error case there is no state change.
- SWAP: requires count >= 2; exchanges tos and nos in one cycle. Otherwise underflow=1 and no change.
- DROP: like POP, but pop_data and pop_valid are not touched.
- NOP, reserved code, or op_valid=0: no state change; pop_valid=0.
- Error flags:
  - Sticky until clr_err.
  - If clr_err and a new error occur in the same cycle, the new error wins and the flag stays 1.
  - A failed op never modifies storage, count or pop_data.
- count uses no wrap-around; it saturates logically at 0 and DEPTH through the guards above.
- Back-to-back ops every cycle are legal. E.g. PUSH then POP in consecutive cycles returns the pushed value, with pop_valid in the cycle after the POP.

Test Plan:
- Reset, then PUSH din=5 → tos=5, count=1, empty=0. Then PUSH din=7 → tos=7, nos=5, count=2.
- From tos=7, nos=5: POP → next cycle pop_valid=1, pop_data=7, tos=5, count=1. POP again → pop_data=5, empty=1, tos=0.
- POP on an empty stack → underflow=1, pop_valid stays 0, count=0. clr_err → underflow=0.
- DEPTH=16: push 0x01..0x10 → full=1, count=16. PUSH 0xAA → overflow=1, tos=0x10. DUP → overflow stays 1, count=16.
- Push 3 then 9; SWAP → tos=3, nos=9. REPLACE din=12 → tos=12, count=2. DUP → count=3, tos=12, nos=12. DROP → count=2, pop_valid=0.
- Push 4 values, then assert reset low mid-cycle → count=0, empty=1, flags=0 immediately. Rebuild with WIDTH=16, DEPTH=4, PUSH 0xBEEF then POP → pop_data=0xBEEF.
